// File: rtl/fifo_pkg.sv
// fifo_pkg: shared gray-code helpers and sizing constants for the async FIFO controllers.
// Revision: 1.0
`default_nettype none

package fifo_pkg;

  // Helpers work on a fixed container width; narrower pointers are zero-extended on entry.
  localparam int GRAY_MAX_W = 13;
  localparam int ASIZE_DEF  = 4;
  localparam int DEPTH      = 2 ** ASIZE_DEF;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin = '0;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational gray-to-binary converter (XOR prefix from the MSB down).
// Revision: 1.0
`default_nettype none

module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wptr_full_ctrl.sv
// fifo_wptr_full_ctrl: write-domain pointer, full/almost-full, level and sticky overflow for the async gray FIFO.
// Revision: 1.0
`default_nettype none

module fifo_wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ASIZE    = ASIZE_DEF,
  parameter int AF_LEVEL = 12
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  input  logic             wovf_clr,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             woverflow
);

  localparam int GW = ASIZE + 1;

  logic [ASIZE:0] wbin;
  logic [ASIZE:0] wbin_next;
  logic [ASIZE:0] wgray_next;
  logic [ASIZE:0] rbin;
  logic [ASIZE:0] level_next;
  logic [ASIZE:0] full_pattern;
  logic           write_ok;
  logic           full_val;
  logic           afull_val;

  gray2bin_conv #(
    .W (GW)
  ) u_rptr_conv (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  assign write_ok   = winc & ~wfull;
  assign wbin_next  = wbin + {{ASIZE{1'b0}}, write_ok};
  assign wgray_next = GW'(bin2gray(GRAY_MAX_W'(wbin_next)));

  // Full when the write pointer is one lap ahead: top two gray bits inverted, rest equal.
  assign full_pattern = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
  assign full_val     = (wgray_next == full_pattern);

  assign level_next = wbin_next - rbin;
  assign afull_val  = (level_next >= GW'(AF_LEVEL));

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= full_val;
      walmost_full <= afull_val;
      wlevel       <= level_next;
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end else if (wovf_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

  assign waddr = wbin[ASIZE-1:0];

endmodule

`default_nettype wire
